wb_rr_arbiter: RTL

- Round-robin arbiter that shares one pipelined Wishbone slave port between N_MASTERS Wishbone masters.
- Typical slave: a generated register bank, e.g. the repeated-interface register blocks.
- Grants the bus for the duration of a master's cycle (cyc held) and tracks outstanding strobes, so a cycle is never handed over while acks are still in flight.
- Sits between CPU/DMA/host-bridge masters and a single register-bank slave.

---
 rtl/wb_rr_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between N_MASTERS masters.
// Optional ack watchdog with ABORT state enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [N_MASTERS-1:0]              m_cyc_i,
  input  logic [N_MASTERS-1:0]              m_stb_i,
  input  logic [N_MASTERS-1:0]              m_we_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  output logic [N_MASTERS-1:0]              m_ack_o,
  output logic [N_MASTERS-1:0]              m_err_o,
  output logic [N_MASTERS-1:0]              m_stall_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_stall_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  output logic [N_MASTERS-1:0]              grant_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
`ifdef WB_ARB_TIMEOUT_EN
    , ST_ABORT
`endif
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full;
  logic             rsp_ok;
  logic             accept;
  logic             m_cyc_g;
  logic             m_stb_g;
  logic             timeout;

  logic [ADDR_WIDTH-1:0] adr_arr [N_MASTERS];
  logic [SEL_W-1:0]      sel_arr [N_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign adr_arr[i] = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_arr[i] = m_sel_i[i*SEL_W +: SEL_W];
    assign dat_arr[i] = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign m_cyc_g = m_cyc_i[g_idx];
  assign m_stb_g = m_stb_i[g_idx];
  assign s_we_o  = m_we_i[g_idx];
  assign s_adr_o = adr_arr[g_idx];
  assign s_sel_o = sel_arr[g_idx];
  assign s_dat_o = dat_arr[g_idx];
  assign m_dat_o = s_dat_i;

  assign full   = (cnt == CNT_W'(MAX_OUTSTANDING));
  // Responses with nothing outstanding are spurious: neither counted nor forwarded.
  assign rsp_ok = (s_ack_i | s_err_i) & (cnt != '0);
  assign accept = s_stb_o & ~s_stall_i;

  // Scan from the farthest candidate down so the nearest requester after the pointer wins.
  always_comb begin
    nxt_idx = g_idx;
    cand    = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(g_idx) + i) % N_MASTERS);
      if (m_cyc_i[cand]) nxt_idx = cand;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;
  logic            wd_active;

  assign wd_active = ((state == ST_BUSY) || (state == ST_DRAIN)) && (cnt != '0);
  assign timeout   = wd_active && !(s_ack_i | s_err_i) && (wdog == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog <= '0;
    end else if (wd_active && !(s_ack_i | s_err_i) && !timeout) begin
      wdog <= wdog + WD_W'(1);
    end else begin
      wdog <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    if (timeout) begin
      cnt_nxt = '0;
    end else begin
      case ({accept, rsp_ok})
        2'b10:   cnt_nxt = cnt + CNT_W'(1);
        2'b01:   cnt_nxt = cnt - CNT_W'(1);
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_stall_o = '1;
    case (state)
      ST_BUSY: begin
        s_cyc_o = m_cyc_g;
        if (timeout) begin
          m_err_o[g_idx] = 1'b1;
        end else begin
          s_stb_o          = m_stb_g & ~full;
          m_stall_o[g_idx] = s_stall_i | full;
          m_ack_o[g_idx]   = s_ack_i & rsp_ok;
          m_err_o[g_idx]   = s_err_i & rsp_ok;
        end
      end
      ST_DRAIN: s_cyc_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      g_idx   <= IDX_W'(N_MASTERS - 1);
      grant_o <= '0;
      cnt     <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            g_idx   <= nxt_idx;
            grant_o <= N_MASTERS'(1) << nxt_idx;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (timeout) begin
            state <= ST_ABORT;
          end else
`endif
          if (!m_cyc_g) begin
            if (cnt_nxt == '0) begin
              state   <= ST_IDLE;
              grant_o <= '0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (timeout) begin
            state <= ST_ABORT;
          end else
`endif
          if (cnt_nxt == '0) begin
            state   <= ST_IDLE;
            grant_o <= '0;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ST_ABORT: begin
          if (!m_cyc_g) begin
            state   <= ST_IDLE;
            grant_o <= '0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
